// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, TX state encoding and the baud divisor helper.
// Used by both the transmitter and the receiver so the two agree on line timing.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic int baud_divide(input int main_clk, input int baud);
    return main_clk / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock show-ahead FIFO; dout is the head entry, push/pop take effect on the clock edge.
// Backpressure through full/empty; a push while full or a pop while empty is ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter behind a small FIFO; tx falls one cycle after a push into an idle block.
// data_ready drops only when the FIFO is full; queued bytes are sent back to back with no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int MAIN_CLK   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        data,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int BAUD_DIVIDE = baud_divide(MAIN_CLK, BAUD);
  localparam int TW          = $clog2(BAUD_DIVIDE);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  logic [1:0]                state;
  logic [TW-1:0]             timer;
  logic [2:0]                bitcnt;
  logic [UART_DATA_BITS-1:0] sr;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      push;
  logic                      pop;
  logic                      bit_end;
  logic                      last_stop;

  assign data_ready = rst_n && !fifo_full;
  assign push       = data_valid && data_ready;
  assign bit_end    = (timer == TW'(BAUD_DIVIDE - 1));
  assign last_stop  = (state == S_STOP) && bit_end && (bitcnt == 3'(STOP_BITS - 1));
  assign pop        = !fifo_empty && ((state == S_IDLE) || last_stop);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  uart_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tx     <= 1'b1;
      timer  <= '0;
      bitcnt <= '0;
      sr     <= '0;
    end else if (pop) begin
      // Frame start, either from idle or straight out of the final stop cycle.
      state  <= S_START;
      tx     <= 1'b0;
      timer  <= '0;
      bitcnt <= '0;
      sr     <= fifo_dout;
    end else begin
      case (state)
        S_IDLE: tx <= 1'b1;
        S_START: begin
          if (bit_end) begin
            state  <= S_DATA;
            timer  <= '0;
            bitcnt <= '0;
            tx     <= sr[0];
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bitcnt == 3'(UART_DATA_BITS - 1)) begin
              state  <= S_STOP;
              bitcnt <= '0;
              tx     <= 1'b1;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              sr     <= sr >> 1;
              tx     <= sr[1];
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (bitcnt == 3'(STOP_BITS - 1)) begin
              state  <= S_IDLE;
              bitcnt <= '0;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter, 8 data bits, no parity, LSB first, with a small input FIFO.
- Counterpart to the team's uart_rx and uses the same MAIN_CLK/BAUD parameterisation.
- Sits between an on-chip byte producer (valid/ready handshake) and the board TX pin.
- Idle line level is high.

Parameters:
- MAIN_CLK, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Derived localparam BAUD_DIVIDE = MAIN_CLK/BAUD, the clock cycles per bit. BAUD_DIVIDE must be >= 2.
- FIFO_DEPTH, 4, input FIFO entries. Power of two, >= 2.
- STOP_BITS, 1, stop bits per frame. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  8  byte to send.
- data_valid  input  1  producer has a byte on data.
- data_ready  output  1  FIFO can accept a byte; a transfer occurs on a rising edge where data_valid && data_ready.
- tx  output  1  serial line, registered.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): tx=1, busy=0, fifo_level=0, FIFO pointers cleared, FSM in IDLE, bit counters 0.
- data_ready is 0 while rst_n is low. Otherwise data_ready = (fifo_level != FIFO_DEPTH), decoded from registered count with no combinational path from data_valid.
- FIFO: a push when data_valid && data_ready stores data. The FSM pops only in IDLE, or in the last cycle of the last stop bit. Push and pop in the same cycle leaves the count unchanged. Pop on empty never occurs. Push is impossible when full.
- Baud timer: counts 0..BAUD_DIVIDE-1. Every bit, including start and stop bits, lasts exactly BAUD_DIVIDE cycles. The timer is cleared on every frame start.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, drive tx=0 and go to START.
  - START: tx=0 for BAUD_DIVIDE cycles, then go to DATA with bitcnt=0.
  - DATA: tx=sr[0]. At each bit end, shift right and increment bitcnt. After bit 7, go to STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIVIDE cycles. In the final cycle, if the FIFO is non-empty (including a byte pushed in that same cycle's earlier edge), pop it and go directly to START, giving a back-to-back frame with no idle gap. Otherwise go to IDLE.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE makes tx fall at edge N+1. The first data bit starts at edge N+1+BAUD_DIVIDE.
- Frame length: (9+STOP_BITS)*BAUD_DIVIDE cycles.
- busy = (state != IDLE) || (fifo_level != 0). It deasserts the cycle after the final stop bit completes with an empty FIFO.
- data is never sampled unless a transfer occurs. data_valid with data_ready low is not an error; the producer must hold.
- Reset mid-frame: tx returns high immediately (asynchronous), the frame is truncated, and the FIFO contents are discarded.

Decomposition:
- Package uart_pkg:
  - function baud_divide(MAIN_CLK, BAUD), shared with uart_rx.
  - enum tx_state_t {IDLE, START, DATA, STOP}.
  - localparam UART_DATA_BITS = 8.
- Sub-module uart_fifo:
  - Synchronous single-clock FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout (show-ahead head), level, full, empty.
  - Async active-low reset.
  - Reusable later as a uart_rx output buffer.

Test Plan:
- MAIN_CLK=1000, BAUD=100 (10 cycles/bit), push 0x55 into idle block:
  - tx low at edge N+1 for 10 cycles.
  - Then 1,0,1,0,1,0,1,0, 10 cycles each.
  - Then high for 10 cycles.
  - busy drops one cycle after the stop bit. Total frame 100 cycles.
- Push 0xA3, 0x00, 0xFF on consecutive cycles:
  - Three frames back to back, 300 cycles total, with no high gap between the stop bit and the next start bit.
  - Decoded bytes appear in order.
- Hold data_valid high with FIFO_DEPTH=4 during a long frame:
  - data_ready falls after 4 accepted bytes beyond the one popped.
  - fifo_level=4.
  - data_ready rises exactly one cycle after the next pop.
  - No byte is lost or duplicated.
- STOP_BITS=2, send 0x01: stop phase is 20 cycles high, total frame 110 cycles.
- Assert rst_n low mid-DATA with 2 bytes queued:
  - tx=1 and fifo_level=0 immediately.
  - After release, no frame is sent until a new push.
- Loopback tx into uart_rx (same MAIN_CLK/BAUD, default values), send 256 random bytes with random valid gaps:
  - uart_rx reports every byte in order.
  - uart_rx overflow stays 0 when data_ready on uart_rx is held high.
